pio_bridge_ch: RTL and testbench
================================

Name: pio_bridge_ch

Overview:
- Parametrised successor to the fixed switch-to-PIO / LED-blink glue. It sits between the board I/O (switches, keys, LEDs) and the HPS parallel-port pair in the FPGA clock domain.
- Input side: synchronises and debounces N_IN raw inputs and latches sticky edge flags that the HPS can clear. Levels, flags and status are packed into the 32-bit word read by the HPS.
- Output side: decodes the 32-bit word written by the HPS into per-LED static or blinking drive from a programmable blink timebase. The timebase also provides a heartbeat.

Parameters:
- N_IN, 10, number of raw input channels (1..15)
- N_LED, 10, number of LED outputs (1..15)
- DEBOUNCE_CYCLES, 500000, consecutive cycles an input must hold a new value before it is accepted (>=2)
- BLINK_HALF, 25000000, clk cycles per blink half-period (>=2)
- EDGE_MODE, 0, edge flag source: 0 = any edge, 1 = rising only, 2 = falling only

Ports:
- clk, in, 1, FPGA fabric clock (50 MHz)
- reset_n, in, 1, asynchronous active-low reset
- din, in, N_IN, raw asynchronous inputs (switches/keys)
- pp_out, in, 32, word written by HPS; already in clk domain
- pp_in, out, 32, word read by HPS
- led, out, N_LED, LED drive
- heartbeat, out, 1, blink phase, 50% duty

Behaviour:
- Reset (async assert, sync deassert handled upstream): every flop clears. This covers sync stages, stable levels, debounce counters, edge flags, blink counter, blink phase, the previous clear bit, pp_in, led and heartbeat, all to 0.
- Sync: each din[i] goes through a 2-flop synchroniser into s[i].
- Debounce, per channel: state stable[i] and counter cnt[i], with width clog2(DEBOUNCE_CYCLES).
  - If s[i]==stable[i], cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1, then stable[i] <= s[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Accept latency: stable changes exactly DEBOUNCE_CYCLES cycles after s changes, provided s holds. Any bounce back restarts the count from 0.
- Edge qualification (EDGE_MODE): a qualifying edge is the cycle stable[i] changes.
  - Mode 0: either direction.
  - Mode 1: only a 0 to 1 change.
  - Mode 2: only a 1 to 0 change.
- Edge flags: flag[i] is set on a qualifying edge and stays set until cleared.
  - Clear event: pp_out[31] differs from its value registered last cycle (toggle protocol; prev bit resets to 0).
  - A clear event zeroes all flags.
  - If a qualifying edge and a clear event occur in the same cycle, that channel's flag ends set (set wins).
- Because stable resets to 0, an input held high through reset produces a rising edge and a flag after debounce. This is intended: it reports the initial state.
- pp_in, registered, 1-cycle latency from its sources:
  - [14:0]: stable levels, zero-extended above N_IN.
  - [29:15]: flags, bit 15+i = flag[i], zero above N_IN.
  - [30]: blink phase.
  - [31]: OR of all flags.
- Blink timebase: bcnt counts 0..BLINK_HALF-1 and wraps to 0. On the wrap cycle phase toggles. Period = 2*BLINK_HALF cycles. heartbeat = phase (registered).
- LED decode:
  - pp_out[14:0] = LED data D.
  - pp_out[29:15] = blink mask M, where M[i] = pp_out[15+i].
  - pp_out[30] is reserved and ignored.
  - led[i] <= M[i] ? (D[i] & phase) : D[i], registered, 1-cycle latency.
  - Bits above N_LED are ignored.
- Width rules: all counters saturate-free; they wrap only by the explicit compare above. No arithmetic overflow is reachable.
- Reset mid-operation: an in-progress debounce count is discarded. Flags and phase are lost. After release, behaviour is as from power-up.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_HALF=3, N_IN=4, N_LED=4):
1. Reset release with din=4'b0000, then din[0] 0 to 1 held → pp_in[0]=1 and pp_in[15]=1 and pp_in[31]=1, appearing exactly 2+4+1 cycles after din changes. Other bits stay 0.
2. din[1] pulses high for 3 cycles, then 0 → pp_in[1] and pp_in[16] never set. A 5-cycle pulse sets both.
3. With flags set, toggle pp_out[31] 0 to 1 → pp_in[29:15]=0 and pp_in[31]=0 one cycle after the clear is registered. Toggle 1 to 0 → clears again. Clear coinciding with a new edge on ch2 → flag 17 remains 1.
4. EDGE_MODE=1: din[0] 1 to 0 → level bit updates, flag stays 0. EDGE_MODE=2 mirror case → flag sets on fall only.
5. pp_out = {D=4'b1011, M=4'b0011} → led[3]=1 steady, led[2]=0, led[1:0] toggle every 3 cycles in phase with heartbeat. Heartbeat period = 6 cycles.
6. Assert reset_n low mid-debounce and mid-blink → led=0, pp_in=0, heartbeat=0 immediately (async). After release, the first flag needs a full 4-cycle debounce.

Source files
------------

// File: rtl/pio_bridge_ch.sv
// Board I/O to HPS parallel-port bridge: synchronised, debounced inputs with sticky
// edge flags on the read word, and a blink timebase driving static or blinking LEDs.
`timescale 1ns/1ps
module pio_bridge_ch #(
    parameter int N_IN            = 10,
    parameter int N_LED           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_HALF      = 25000000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IN-1:0]  din,
    input  logic [31:0]      pp_out,
    output logic [31:0]      pp_in,
    output logic [N_LED-1:0] led,
    output logic             heartbeat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [N_IN-1:0]  sync_a;
    logic [N_IN-1:0]  sync_b;
    logic [N_IN-1:0]  stable;
    logic [CW-1:0]    cnt [N_IN];
    logic [N_IN-1:0]  accept;
    logic [N_IN-1:0]  qual;
    logic [N_IN-1:0]  flag;
    logic             clr_prev;
    logic             clear_evt;
    logic [BW-1:0]    bcnt;
    logic             phase;
    logic [N_LED-1:0] led_data;
    logic [N_LED-1:0] led_mask;
    logic             unused_pp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
        end
    end

    // A channel is accepted on the cycle its disagreement count reaches the last value.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_IN; i++) begin
            accept[i] = (sync_b[i] != stable[i]) && (cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_b[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync_b[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        case (EDGE_MODE)
            1:       qual = accept & sync_b;
            2:       qual = accept & ~sync_b;
            default: qual = accept;
        endcase
    end

    assign clear_evt = pp_out[31] ^ clr_prev;

    // A new edge in the same cycle as a clear leaves its flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_prev <= 1'b0;
            flag     <= '0;
        end else begin
            clr_prev <= pp_out[31];
            flag     <= (clear_evt ? '0 : flag) | qual;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    assign led_data  = pp_out[N_LED-1:0];
    assign led_mask  = pp_out[15 +: N_LED];
    assign unused_pp = ^pp_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp_in     <= '0;
            led       <= '0;
            heartbeat <= 1'b0;
        end else begin
            pp_in     <= {|flag, phase, 15'(flag), 15'(stable)};
            led       <= (led_data & ~led_mask) | (led_data & led_mask & {N_LED{phase}});
            heartbeat <= phase;
        end
    end

endmodule

// File: tb/tb_pio_bridge_ch.sv
// Bench for pio_bridge_ch: three instances (one per edge mode) share stimulus and are
// compared every cycle against a window-based reference model, plus directed timing checks.
`timescale 1ns/1ps
module tb_pio_bridge_ch;
    localparam int NI = 4;
    localparam int NL = 4;
    localparam int DB = 4;
    localparam int BH = 3;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [NI-1:0] din     = '0;
    logic [31:0]   pp_out  = '0;
    logic [31:0]   pp_in_m [3];
    logic [NL-1:0] led_m   [3];
    logic          hb_m    [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pio_bridge_ch #(
            .N_IN(NI), .N_LED(NL), .DEBOUNCE_CYCLES(DB), .BLINK_HALF(BH), .EDGE_MODE(g)
        ) dut (
            .clk(clk), .reset_n(reset_n), .din(din), .pp_out(pp_out),
            .pp_in(pp_in_m[g]), .led(led_m[g]), .heartbeat(hb_m[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an input is accepted once its synchronised value has disagreed with
    // the accepted level for DB consecutive samples; blink phase is a closed form of cycle count.
    logic [NI-1:0] hist [DB+2];
    logic [NI-1:0] m_stable, m_acc, m_next;
    logic [NI-1:0] m_flag [3];
    logic          m_phase, m_prev31, m_clr, m_held;
    int unsigned   m_k;
    logic [31:0]   exp_pp_in [3];
    logic [NL-1:0] exp_led;
    logic          exp_hb;

    function automatic logic [31:0] pack_word(input logic [NI-1:0] st, input logic [NI-1:0] fl,
                                              input logic ph);
        logic [31:0] w;
        w = '0;
        w[NI-1:0]  = st;
        w[15 +: NI] = fl;
        w[30]      = ph;
        w[31]      = |fl;
        return w;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < DB + 2; j++) hist[j] = '0;
            for (int g = 0; g < 3; g++) begin
                m_flag[g]    = '0;
                exp_pp_in[g] = '0;
            end
            m_stable = '0;
            m_phase  = 1'b0;
            m_prev31 = 1'b0;
            m_k      = 0;
            exp_led  = '0;
            exp_hb   = 1'b0;
        end else begin
            for (int g = 0; g < 3; g++) exp_pp_in[g] = pack_word(m_stable, m_flag[g], m_phase);
            exp_led = pp_out[NL-1:0] & (~pp_out[15 +: NL] | {NL{m_phase}});
            exp_hb  = m_phase;
            for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = din;
            for (int i = 0; i < NI; i++) begin
                m_held = 1'b1;
                for (int j = 2; j < DB + 2; j++) if (hist[j][i] == m_stable[i]) m_held = 1'b0;
                m_acc[i] = m_held;
            end
            m_next   = m_stable ^ m_acc;
            m_clr    = (pp_out[31] != m_prev31);
            m_prev31 = pp_out[31];
            for (int g = 0; g < 3; g++) if (m_clr) m_flag[g] = '0;
            m_flag[0] = m_flag[0] | m_acc;
            m_flag[1] = m_flag[1] | (m_acc & m_next);
            m_flag[2] = m_flag[2] | (m_acc & ~m_next);
            m_stable  = m_next;
            m_k++;
            m_phase = ((m_k / BH) % 2) == 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int g = 0; g < 3; g++) begin
                check_eq($sformatf("pp_in m%0d", g), pp_in_m[g], exp_pp_in[g]);
                check_eq($sformatf("led m%0d", g), 32'(led_m[g]), 32'(exp_led));
                check_eq($sformatf("heartbeat m%0d", g), 32'(hb_m[g]), 32'(exp_hb));
            end
        end
    end

    initial begin
        int c, r1, r2;
        logic prev;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset pp_in", pp_in_m[0], 32'h0);
        check_eq("reset led", 32'(led_m[0]), 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // accept latency from a raw input change
        din = 4'b0001;
        c = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (pp_in_m[0][0]) begin c = t; break; end
        end
        check_eq("ch0 accept latency", c, 7);
        check_eq("ch0 word", pp_in_m[0] & 32'hBFFF_FFFF, 32'h8000_8001);

        // short pulse rejected, long pulse accepted
        din = 4'b0011;
        repeat (3) @(negedge clk);
        din = 4'b0001;
        repeat (10) @(negedge clk);
        check_eq("pulse3 level", 32'(pp_in_m[0][1]), 0);
        check_eq("pulse3 flag", 32'(pp_in_m[0][16]), 0);
        din = 4'b0011;
        repeat (5) @(negedge clk);
        din = 4'b0001;
        repeat (12) @(negedge clk);
        check_eq("pulse5 flag", 32'(pp_in_m[0][16]), 1);

        // toggle clear 0->1
        pp_out[31] = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("clear rise m0", pp_in_m[0] & 32'hBFFF_8000, 32'h0);
        check_eq("clear rise m1", pp_in_m[1] & 32'hBFFF_8000, 32'h0);

        // falling edge: only any-edge and falling-only instances flag it
        din = 4'b0000;
        repeat (10) @(negedge clk);
        check_eq("fall level m1", 32'(pp_in_m[1][0]), 0);
        check_eq("fall flag m1", 32'(pp_in_m[1][15]), 0);
        check_eq("fall flag m2", 32'(pp_in_m[2][15]), 1);

        // toggle clear 1->0
        pp_out[31] = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("clear fall m0", pp_in_m[0] & 32'hBFFF_8000, 32'h0);
        check_eq("clear fall m2", pp_in_m[2] & 32'hBFFF_8000, 32'h0);

        // clear lands on the same cycle ch2 is accepted
        din = 4'b0100;
        repeat (5) @(negedge clk);
        pp_out[31] = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("set wins m0", 32'(pp_in_m[0][17]), 1);
        check_eq("set wins clr m0", 32'(pp_in_m[0][15]), 0);
        check_eq("mode2 rise", 32'(pp_in_m[2][17]), 0);

        // LED decode: D=1011, blink mask on bits 1:0
        pp_out = 32'h8001_800B;
        repeat (2) @(negedge clk);
        check_eq("led3 steady", 32'(led_m[0][3]), 1);
        check_eq("led2 off", 32'(led_m[0][2]), 0);
        r1 = -1;
        r2 = -1;
        prev = hb_m[0];
        for (int t = 0; t < 30 && r2 < 0; t++) begin
            @(negedge clk);
            if (hb_m[0] && !prev) begin
                if (r1 < 0) r1 = t;
                else r2 = t;
            end
            prev = hb_m[0];
        end
        check_eq("heartbeat period", r2 - r1, 6);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) din = din ^ NI'($urandom);
            if ($urandom_range(0, 15) == 0) pp_out[31] = ~pp_out[31];
            if ($urandom_range(0, 7) == 0) pp_out[30:0] = 31'($urandom);
        end

        // asynchronous reset mid-debounce and mid-blink
        pp_out = 32'h0001_800B;
        din = 4'b0101;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("async rst pp_in m%0d", g), pp_in_m[g], 32'h0);
            check_eq($sformatf("async rst led m%0d", g), 32'(led_m[g]), 32'h0);
            check_eq($sformatf("async rst hb m%0d", g), 32'(hb_m[g]), 32'h0);
        end
        @(negedge clk);
        din = 4'b1000;
        reset_n = 1'b1;
        c = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (pp_in_m[0][18]) begin c = t; break; end
        end
        check_eq("post-reset flag latency", c, 7);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
